// File: rtl/conv3x3_stream_ctrl.sv
// Raster-stream sequencer for a 3x3 convolution datapath: line buffers, column
// issue, enable-gated tag pipeline that labels each result, and end-of-frame drain.
module conv3x3_stream_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CONV_LAT = 4,
    parameter int XW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_pixel,
    output logic          conv_valid,
    output logic [23:0]   conv_data,
    input  logic [34:0]   conv_result,
    output logic          out_valid,
    output logic [34:0]   out_data,
    output logic [XW-1:0] out_x,
    output logic [XW-1:0] out_y,
    output logic          out_eof,
    output logic          busy
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int FW = $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef struct packed {
        logic          complete;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic          last;
    } tag_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, y_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [7:0]      lb0_q [IMG_W];
    logic [7:0]      lb1_q [IMG_W];
    logic            conv_valid_q;
    logic [23:0]     conv_data_q;
    tag_t            beat_tag_q;
    tag_t            tag_q [CONV_LAT];
    logic            res_vld_q;
    tag_t            res_tag_q;

    logic            accept, x_last, y_last, flush_done;
    logic [AW-1:0]   xi;

    assign in_ready   = (state_q != FLUSH);
    assign accept     = in_valid && in_ready;
    assign x_last     = (x_q == XW'(IMG_W - 1));
    assign y_last     = (y_q == XW'(IMG_H - 1));
    assign flush_done = (flush_cnt_q == FW'(CONV_LAT - 1));
    assign xi         = x_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (accept && x_last && y_last) state_d = FLUSH;
            FLUSH:   if (flush_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line buffers are deliberately left unreset; rows y<2 are flagged incomplete.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[xi] <= lb0_q[xi];
            lb0_q[xi] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            flush_cnt_q  <= '0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            beat_tag_q   <= '0;
            res_vld_q    <= 1'b0;
            res_tag_q    <= '0;
            for (int i = 0; i < CONV_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            conv_valid_q <= accept || (state_q == FLUSH);
            conv_data_q  <= '0;
            beat_tag_q   <= '0;
            if (accept) begin
                conv_data_q <= {lb1_q[xi], lb0_q[xi], in_pixel};
                beat_tag_q  <= '{complete: (x_q >= XW'(2)) && (y_q >= XW'(2)),
                                 x: x_q - 1'b1, y: y_q - 1'b1, last: x_last && y_last};
                x_q <= x_last ? '0 : x_q + 1'b1;
                if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
            end
            flush_cnt_q <= (state_q == FLUSH && !flush_done) ? flush_cnt_q + 1'b1 : '0;

            // Tags advance only on datapath beats so they stay aligned across gaps.
            res_vld_q <= conv_valid_q;
            if (conv_valid_q) begin
                tag_q[0]  <= beat_tag_q;
                for (int i = 1; i < CONV_LAT; i++) tag_q[i] <= tag_q[i-1];
                res_tag_q <= tag_q[CONV_LAT-1];
            end
        end
    end

    assign conv_valid = conv_valid_q;
    assign conv_data  = conv_data_q;
    assign out_valid  = res_vld_q && res_tag_q.complete;
    assign out_data   = out_valid ? conv_result : '0;
    assign out_x      = out_valid ? res_tag_q.x : '0;
    assign out_y      = out_valid ? res_tag_q.y : '0;
    assign out_eof    = out_valid && res_tag_q.last;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Directed bench: 4x4 and 5x3 instances driven against a gated sharpen-kernel
// datapath model; results are checked against hand-computed centres and values.
module tb_conv3x3_stream_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 4x4 instance
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  in_pixel = '0;
    logic        conv_valid;
    logic [23:0] conv_data;
    logic [34:0] conv_result;
    logic        out_valid, out_eof, busy;
    logic [34:0] out_data;
    logic [9:0]  out_x, out_y;

    // 5x3 instance
    logic        in_valid5 = 1'b0, in_ready5;
    logic [7:0]  in_pixel5 = '0;
    logic        conv_valid5;
    logic [23:0] conv_data5;
    logic [34:0] conv_result5;
    logic        out_valid5, out_eof5, busy5;
    logic [34:0] out_data5;
    logic [9:0]  out_x5, out_y5;

    conv3x3_stream_ctrl #(.IMG_W(4), .IMG_H(4), .CONV_LAT(4), .XW(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .conv_valid(conv_valid), .conv_data(conv_data),
        .conv_result(conv_result), .out_valid(out_valid), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_eof(out_eof), .busy(busy));

    conv3x3_stream_ctrl #(.IMG_W(5), .IMG_H(3), .CONV_LAT(4), .XW(10)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_pixel(in_pixel5), .conv_valid(conv_valid5), .conv_data(conv_data5),
        .conv_result(conv_result5), .out_valid(out_valid5), .out_data(out_data5),
        .out_x(out_x5), .out_y(out_y5), .out_eof(out_eof5), .busy(busy5));

    // Sharpen kernel on the window whose right column is the current beat.
    function automatic logic [34:0] sharp(input logic [23:0] l, input logic [23:0] m,
                                          input logic [23:0] r);
        int s;
        s = 5 * int'(m[15:8]) - int'(m[23:16]) - int'(m[7:0]) - int'(l[15:8]) - int'(r[15:8]);
        return 35'(s);
    endfunction

    // Enable-gated datapath models: LAT stages plus output register.
    logic [23:0] c1 = '0, c2 = '0, c15 = '0, c25 = '0;
    logic [34:0] p [4];
    logic [34:0] p5 [4];
    logic [34:0] r = '0, r5 = '0;
    assign conv_result  = r;
    assign conv_result5 = r5;

    always @(posedge clk) begin
        if (conv_valid) begin
            c2 <= c1; c1 <= conv_data;
            p[0] <= sharp(c2, c1, conv_data);
            for (int i = 1; i < 4; i++) p[i] <= p[i-1];
            r <= p[3];
        end
        if (conv_valid5) begin
            c25 <= c15; c15 <= conv_data5;
            p5[0] <= sharp(c25, c15, conv_data5);
            for (int j = 1; j < 4; j++) p5[j] <= p5[j-1];
            r5 <= p5[3];
        end
    end

    logic [55:0] oq[$], oq5[$];
    logic [23:0] cq[$];
    always @(negedge clk) begin
        if (out_valid)  oq.push_back({out_eof, out_y, out_x, out_data});
        if (out_valid5) oq5.push_back({out_eof5, out_y5, out_x5, out_data5});
        if (conv_valid) cq.push_back(conv_data);
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] rec(input int d, input int x, input int y, input bit e);
        return {e, 10'(y), 10'(x), 35'(d)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input bit sel, input bit ramp, input bit gaps, input int npix);
        int n = 0, cyc = 0;
        bit v, acc;
        while (n < npix && cyc < 2000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) begin
                in_valid5 = v; in_pixel5 = ramp ? 8'(n) : 8'd10; acc = v && in_ready5;
            end else begin
                in_valid = v; in_pixel = ramp ? 8'(n) : 8'd10; acc = v && in_ready;
            end
            @(posedge clk); #1;
            if (acc) n++;
            cyc++;
        end
        in_valid = 1'b0; in_valid5 = 1'b0;
        chk("send_done", 64'(n), 64'(npix));
    endtask

    task automatic chk4(input string tag, input int d0, input int d1, input int d2,
                        input int d3);
        chk({tag, "_cnt"}, 64'(oq.size()), 64'd4);
        chk({tag, "_r0"}, 64'(oq[0]), 64'(rec(d0, 1, 1, 0)));
        chk({tag, "_r1"}, 64'(oq[1]), 64'(rec(d1, 2, 1, 0)));
        chk({tag, "_r2"}, 64'(oq[2]), 64'(rec(d2, 1, 2, 0)));
        chk({tag, "_r3"}, 64'(oq[3]), 64'(rec(d3, 2, 2, 1)));
    endtask

    initial begin
        int n, rl;
        for (int i = 0; i < 4; i++) begin p[i] = '0; p5[i] = '0; end
        cycles(2);
        reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_conv_valid", 64'(conv_valid), 64'd0);
        chk("rst_conv_data", 64'(conv_data), 64'd0);
        chk("rst_out", 64'({out_valid, out_eof, out_data, out_x, out_y}), 64'd0);

        // constant 10, no gaps; busy/in_ready low for exactly the drain
        oq.delete(); cq.delete();
        send(0, 0, 0, 16);
        n = 0; rl = 0;
        while (busy && n < 20) begin
            if (!in_ready) rl++;
            @(posedge clk); #1; n++;
        end
        chk("busy_fall", 64'(n), 64'd4);
        chk("ready_low", 64'(rl), 64'd4);
        chk("idle_ready", 64'(in_ready), 64'd1);
        cycles(8);
        chk4("const", 10, 10, 10, 10);
        chk("const_beats", 64'(cq.size()), 64'd20);

        // same frame with random gaps
        oq.delete(); cq.delete();
        send(0, 0, 1, 16);
        cycles(16);
        chk4("gaps", 10, 10, 10, 10);
        chk("gaps_beats", 64'(cq.size()), 64'd20);

        // ramp x+4y: sharpen of a linear ramp returns the centre value
        oq.delete(); cq.delete();
        send(0, 1, 0, 16);
        cycles(16);
        chk("ramp_col22", 64'(cq[10]), 64'h02060A);
        chk("ramp_flush_beat", 64'(cq[19]), 64'd0);
        chk4("ramp", 5, 6, 9, 10);

        // back-to-back frames, in_valid held high
        oq.delete();
        n = 0; rl = 0;
        for (int c = 0; c < 200 && n < 32; c++) begin
            in_valid = 1'b1; in_pixel = 8'd10;
            if (!in_ready) rl++;
            if (in_ready) n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b_done", 64'(n), 64'd32);
        cycles(16);
        chk("b2b_ready_low", 64'(rl), 64'd4);
        chk("b2b_cnt", 64'(oq.size()), 64'd8);
        chk("b2b_eof1", 64'(oq[3]), 64'(rec(10, 2, 2, 1)));
        chk("b2b_f2_first", 64'(oq[4]), 64'(rec(10, 1, 1, 0)));
        chk("b2b_eof2", 64'(oq[7]), 64'(rec(10, 2, 2, 1)));

        // reset during flush aborts outstanding results
        send(0, 0, 0, 16);
        cycles(1);
        chk("pre_rst_flush", 64'(in_ready), 64'd0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        oq.delete();
        cycles(12);
        chk("midrst_no_out", 64'(oq.size()), 64'd0);

        // 5x3 frame: one result line, no wrap across lines
        oq5.delete();
        send(1, 1, 0, 15);
        cycles(16);
        chk("w5_cnt", 64'(oq5.size()), 64'd3);
        chk("w5_r0", 64'(oq5[0]), 64'(rec(6, 1, 1, 0)));
        chk("w5_r1", 64'(oq5[1]), 64'(rec(7, 2, 1, 0)));
        chk("w5_r2", 64'(oq5[2]), 64'(rec(8, 3, 1, 1)));
        chk("w5_idle", 64'({busy5, in_ready5}), 64'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
